// File: rtl/weight_mac_sequencer.sv
// Weight/pixel BRAM sequencer: loads a DEPTH-word weight row, then streams both buffers
// through a signed Q8.8 multiply-accumulate and emits a saturated partial sum with DONE.
module weight_mac_sequencer #(
   parameter int unsigned DEPTH = 28,
   parameter int unsigned AW    = 5,
   parameter int unsigned DW    = 16,
   parameter int unsigned ACC_W = 40,
   parameter int unsigned FRAC  = 8
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          START,
   input  logic          LOAD_VALID,
   input  logic [DW-1:0] LOAD_DATA,
   output logic          LOAD_READY,
   output logic          BUSY,
   output logic          DONE,
   output logic [DW-1:0] Y,
   output logic          SAT,
   output logic [AW-1:0] W_ADDR,
   output logic          W_EN,
   output logic          W_WE,
   output logic [DW-1:0] W_DI,
   input  logic [DW-1:0] W_DO,
   output logic [AW-1:0] X_ADDR,
   output logic          X_EN,
   input  logic [DW-1:0] X_DO
);

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StLoad  = 3'd1;
   localparam logic [2:0] StRun   = 3'd2;
   localparam logic [2:0] StDrain = 3'd3;
   localparam logic [2:0] StFin   = 3'd4;

   localparam logic [AW-1:0]           LastAddr = AW'(DEPTH - 1);
   localparam logic signed [ACC_W-1:0] YMax     = (ACC_W'(1) << (DW - 1)) - ACC_W'(1);
   localparam logic signed [ACC_W-1:0] YMin     = -YMax - ACC_W'(1);

   logic [2:0]              state_q, state_d;
   logic [AW-1:0]           addr_q, addr_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic                    rd_vld_q, rd_vld_d;
   logic                    done_q, done_d;
   logic [DW-1:0]           y_q, y_d;
   logic                    sat_q, sat_d;

   logic                    wr, rd;
   logic signed [2*DW-1:0]  prod;
   logic signed [ACC_W-1:0] shifted;

   always_comb begin
      LOAD_READY = ((state_q == StIdle) && !START) || (state_q == StLoad);
      // A write asserted during reset would land at the BRAM's negedge; suppress it.
      wr         = LOAD_VALID && LOAD_READY && !RST;
      rd         = (state_q == StRun);
      W_EN       = wr || rd;
      W_WE       = wr;
      X_EN       = rd;
      W_ADDR     = addr_q;
      X_ADDR     = addr_q;
      W_DI       = LOAD_DATA;
      BUSY       = (state_q != StIdle);
      DONE       = done_q;
      Y          = y_q;
      SAT        = sat_q;
      prod       = $signed(W_DO) * $signed(X_DO);
      shifted    = acc_q >>> FRAC;
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      acc_d    = acc_q;
      rd_vld_d = rd;
      done_d   = 1'b0;
      y_d      = y_q;
      sat_d    = sat_q;
      if (rd_vld_q) begin
         acc_d = acc_q + {{(ACC_W - 2 * DW){prod[2*DW-1]}}, prod};
      end
      case (state_q)
         StIdle, StLoad: begin
            if (state_q == StIdle && START) begin
               state_d = StRun;
               addr_d  = '0;
               acc_d   = '0;
            end else if (wr) begin
               if (addr_q == LastAddr) begin
                  addr_d  = '0;
                  state_d = StIdle;
               end else begin
                  addr_d  = addr_q + AW'(1);
                  state_d = StLoad;
               end
            end
         end
         StRun: begin
            if (addr_q == LastAddr) begin
               addr_d  = '0;
               state_d = StDrain;
            end else begin
               addr_d = addr_q + AW'(1);
            end
         end
         StDrain: state_d = StFin;
         StFin: begin
            if (shifted > YMax) begin
               y_d   = YMax[DW-1:0];
               sat_d = 1'b1;
            end else if (shifted < YMin) begin
               y_d   = YMin[DW-1:0];
               sat_d = 1'b1;
            end else begin
               y_d   = shifted[DW-1:0];
               sat_d = 1'b0;
            end
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= StIdle;
         addr_q   <= '0;
         acc_q    <= '0;
         rd_vld_q <= 1'b0;
         done_q   <= 1'b0;
         y_q      <= '0;
         sat_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         acc_q    <= acc_d;
         rd_vld_q <= rd_vld_d;
         done_q   <= done_d;
         y_q      <= y_d;
         sat_q    <= sat_d;
      end
   end

endmodule

// File: tb/tb_weight_mac_sequencer.sv
// Directed bench for weight_mac_sequencer with negedge-clocked BRAM models for weights/pixels.
module tb_weight_mac_sequencer;

   logic        CLK = 1'b0;
   logic        RST, START, LOAD_VALID;
   logic [15:0] LOAD_DATA;
   logic        LOAD_READY, BUSY, DONE, SAT, W_EN, W_WE, X_EN;
   logic [15:0] Y, W_DI;
   logic [15:0] W_DO = '0;
   logic [15:0] X_DO = '0;
   logic [4:0]  W_ADDR, X_ADDR;

   logic [15:0] wmem [28];
   logic [15:0] xmem [28];
   logic [15:0] wset [28];

   int checks = 0;
   int errors = 0;

   weight_mac_sequencer dut (
      .CLK(CLK), .RST(RST), .START(START), .LOAD_VALID(LOAD_VALID), .LOAD_DATA(LOAD_DATA),
      .LOAD_READY(LOAD_READY), .BUSY(BUSY), .DONE(DONE), .Y(Y), .SAT(SAT),
      .W_ADDR(W_ADDR), .W_EN(W_EN), .W_WE(W_WE), .W_DI(W_DI), .W_DO(W_DO),
      .X_ADDR(X_ADDR), .X_EN(X_EN), .X_DO(X_DO)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (W_EN) begin
         if (W_WE) wmem[W_ADDR] <= W_DI;
         else      W_DO <= wmem[W_ADDR];
      end
      if (X_EN) X_DO <= xmem[X_ADDR];
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Loads wset; optionally raises START alongside word 10, which must be ignored in LOAD.
   task automatic load_w(input bit poke_start);
      for (int k = 0; k < 28; k++) begin
         LOAD_VALID = 1'b1;
         LOAD_DATA  = wset[k];
         START      = poke_start && (k == 10);
         step();
      end
      LOAD_VALID = 1'b0;
      START      = 1'b0;
   endtask

   task automatic run_pass(input string tag, input logic [15:0] exp_y, input logic exp_sat);
      int n;
      START = 1'b1;
      step();
      START = 1'b0;
      n = 0;
      while (!DONE && n < 100) begin
         step();
         n++;
      end
      chk({tag, "_latency"}, n, 30);
      chk({tag, "_y"}, Y, exp_y);
      chk({tag, "_sat"}, SAT, exp_sat);
      step();
      chk({tag, "_done_pulse"}, {DONE, BUSY}, 2'b00);
      chk({tag, "_y_held"}, Y, exp_y);
   endtask

   initial begin
      int dones;
      logic we_seen, rdy_seen;
      RST = 1'b1; START = 1'b0; LOAD_VALID = 1'b0; LOAD_DATA = '0;
      step();
      step();
      RST = 1'b0;
      chk("reset_ready_busy", {LOAD_READY, BUSY}, 2'b10);
      chk("reset_outputs", {DONE, SAT, Y}, '0);
      chk("reset_bram", {W_EN, W_WE, X_EN, W_ADDR, X_ADDR}, '0);

      // Uniform 1.0 x 1.0 over 28 words.
      for (int k = 0; k < 28; k++) begin
         wset[k] = 16'h0100;
         xmem[k] = 16'h0100;
      end
      LOAD_VALID = 1'b1; LOAD_DATA = wset[0];
      @(negedge CLK);
      chk("idle_write_strobe", {W_EN, W_WE, W_ADDR}, {2'b11, 5'd0});
      step();
      chk("load_busy_ready", {BUSY, LOAD_READY, W_ADDR}, {2'b11, 5'd1});
      for (int k = 1; k < 28; k++) begin
         LOAD_DATA = wset[k];
         step();
      end
      LOAD_VALID = 1'b0;
      chk("load_wrap_idle", {BUSY, W_ADDR}, 6'd0);
      chk("load_mem_last", wmem[27], 16'h0100);
      run_pass("uniform", 16'h1C00, 1'b0);

      // START pulses while busy and LOAD_VALID during RUN must have no effect.
      START = 1'b1;
      step();
      START = 1'b0;
      dones = 0; we_seen = 1'b0; rdy_seen = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         START      = (c == 3) || (c == 10);
         LOAD_VALID = (c >= 2) && (c <= 20);
         LOAD_DATA  = 16'hDEAD;
         @(negedge CLK);
         if (c <= 29) begin
            we_seen  = we_seen | W_WE;
            rdy_seen = rdy_seen | LOAD_READY;
         end
         step();
         if (DONE) dones++;
      end
      START = 1'b0; LOAD_VALID = 1'b0;
      chk("busy_start_one_done", dones, 1);
      chk("run_no_write", we_seen, 1'b0);
      chk("run_not_ready", rdy_seen, 1'b0);
      chk("busy_start_y", Y, 16'h1C00);

      // Reset in the middle of RUN at address 12.
      START = 1'b1;
      step();
      START = 1'b0;
      for (int k = 1; k <= 12; k++) step();
      chk("mid_run_addr", {W_EN, X_EN, W_ADDR}, {2'b11, 5'd12});
      RST = 1'b1;
      step();
      RST = 1'b0;
      chk("rst_enables_drop", {W_EN, X_EN, W_WE, BUSY}, 4'b0);
      chk("rst_y_sat", {Y, SAT}, 17'd0);
      dones = 0;
      for (int k = 0; k < 35; k++) begin
         step();
         if (DONE) dones++;
      end
      chk("rst_no_done", dones, 0);
      run_pass("after_rst", 16'h1C00, 1'b0);

      // Ramp weights, one-hot pixel at address 5.
      for (int k = 0; k < 28; k++) begin
         wset[k] = 16'(k * 256);
         xmem[k] = (k == 5) ? 16'h0100 : 16'h0000;
      end
      load_w(1'b1);
      chk("ramp_load_idle", {BUSY, W_ADDR}, 6'd0);
      run_pass("onehot", 16'h0500, 1'b0);

      // Positive and negative saturation.
      for (int k = 0; k < 28; k++) begin
         wset[k] = 16'h7FFF;
         xmem[k] = 16'h7FFF;
      end
      load_w(1'b0);
      run_pass("sat_pos", 16'h7FFF, 1'b1);
      for (int k = 0; k < 28; k++) wset[k] = 16'h8000;
      load_w(1'b0);
      run_pass("sat_neg", 16'h8000, 1'b1);

      // START and LOAD_VALID together in IDLE: START wins, no write.
      START = 1'b1; LOAD_VALID = 1'b1; LOAD_DATA = 16'h1234;
      @(negedge CLK);
      chk("start_wins_strobe", {LOAD_READY, W_WE}, 2'b00);
      step();
      START = 1'b0; LOAD_VALID = 1'b0;
      chk("start_wins_run", {BUSY, W_EN, X_EN, W_WE}, 4'b1110);
      for (int k = 0; k < 35; k++) step();
      chk("start_wins_mem", wmem[0], 16'h8000);
      chk("start_wins_y", {Y, SAT}, {16'h8000, 1'b1});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
